// File: rtl/muon_coincidence_array_if.sv
// Event-readout bundle for muon_coincidence_array: discriminator inputs, FIFO pop and head-entry outputs.
// The slave modport is the detector side; the master modport is the upstream/readout side.
interface muon_coincidence_array_if #(
    parameter int NUM_CH     = 4,
    parameter int TS_WIDTH   = 64,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0]   hit;
    logic                rd_en;
    logic [TS_WIDTH-1:0] timestamp_out;
    logic [NUM_CH-1:0]   hit_mask_out;
    logic                event_valid;
    logic                buffer_empty;
    logic                buffer_full;
    logic [LEVEL_W-1:0]  fifo_level;
    logic [15:0]         overflow_count;

    modport master (
        output hit, rd_en,
        input  timestamp_out, hit_mask_out, event_valid, buffer_empty,
               buffer_full, fifo_level, overflow_count
    );

    modport slave (
        input  hit, rd_en,
        output timestamp_out, hit_mask_out, event_valid, buffer_empty,
               buffer_full, fifo_level, overflow_count
    );
endinterface

// File: rtl/muon_coincidence_array.sv
// N-channel coincidence finder: opens a WINDOW-cycle window on the first rising edge and queues qualifying events.
// Optional post-window dead time is enabled by defining MUON_DEADTIME_EN.
module muon_coincidence_array #(
    parameter int NUM_CH     = 4,
    parameter int MIN_HITS   = 2,
    parameter int WINDOW     = 8,
    parameter int TS_WIDTH   = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int DEADTIME   = 4
) (
    input  logic clk,
    input  logic reset_n,
    muon_coincidence_array_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WIN_W = $clog2(WINDOW) + 1;

    if (NUM_CH < 2 || NUM_CH > 16 || MIN_HITS < 1 || MIN_HITS > NUM_CH || WINDOW < 2 ||
        DEADTIME < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badParams
        $error("muon_coincidence_array: illegal parameter set");
    end

`ifdef MUON_DEADTIME_EN
    localparam int DEAD_W = $clog2(DEADTIME) + 1;
    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DEAD} state_t;
    logic [DEAD_W-1:0] r_deadCnt;
`else
    typedef enum logic {S_IDLE, S_OPEN} state_t;
`endif

    state_t              r_state;
    logic [TS_WIDTH-1:0] r_tsCount;
    logic [TS_WIDTH-1:0] r_tsLat;
    logic [NUM_CH-1:0]   r_hitD;
    logic [NUM_CH-1:0]   r_mask;
    logic [WIN_W-1:0]    r_winCnt;
    logic [PTR_W:0]      r_wrPtr;
    logic [PTR_W:0]      r_rdPtr;
    logic [15:0]         r_overflow;
    logic [TS_WIDTH-1:0] r_memTs   [FIFO_DEPTH];
    logic [NUM_CH-1:0]   r_memMask [FIFO_DEPTH];

    logic [NUM_CH-1:0]   w_edge;
    logic [NUM_CH-1:0]   w_closeMask;
    logic                w_close;
    logic                w_push;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_write;

    function automatic int popCount(input logic [NUM_CH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    assign w_edge      = bus.hit & ~r_hitD;
    assign w_closeMask = r_mask | w_edge;
    assign w_close     = (r_state == S_OPEN) && (r_winCnt == WIN_W'(WINDOW - 1));
    assign w_push      = w_close && (popCount(w_closeMask) >= MIN_HITS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tsCount <= '0;
            r_hitD    <= '0;
        end else begin
            r_tsCount <= r_tsCount + 1'b1;
            r_hitD    <= bus.hit;
        end
    end

    // Closing-cycle edges still land in the mask; the qualified mask is pushed directly from w_closeMask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_tsLat  <= '0;
            r_winCnt <= '0;
`ifdef MUON_DEADTIME_EN
            r_deadCnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_edge) begin
                        r_state  <= S_OPEN;
                        r_mask   <= w_edge;
                        r_tsLat  <= r_tsCount;
                        r_winCnt <= WIN_W'(1);
                    end
                end
                S_OPEN: begin
                    r_mask   <= w_closeMask;
                    r_winCnt <= r_winCnt + WIN_W'(1);
                    if (w_close) begin
`ifdef MUON_DEADTIME_EN
                        r_state   <= S_DEAD;
                        r_deadCnt <= '0;
`else
                        r_state   <= S_IDLE;
`endif
                    end
                end
`ifdef MUON_DEADTIME_EN
                S_DEAD: begin
                    if (r_deadCnt == DEAD_W'(DEADTIME - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_deadCnt <= r_deadCnt + DEAD_W'(1);
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_pop   = bus.rd_en && !w_empty;
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_memTs[r_wrPtr[PTR_W-1:0]]   <= r_tsLat;
            r_memMask[r_wrPtr[PTR_W-1:0]] <= w_closeMask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= '0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_write && (r_overflow != 16'hFFFF)) begin
                r_overflow <= r_overflow + 16'd1;
            end
        end
    end

    assign bus.timestamp_out  = w_empty ? '0 : r_memTs[r_rdPtr[PTR_W-1:0]];
    assign bus.hit_mask_out   = w_empty ? '0 : r_memMask[r_rdPtr[PTR_W-1:0]];
    assign bus.event_valid    = !w_empty;
    assign bus.buffer_empty   = w_empty;
    assign bus.buffer_full    = w_full;
    assign bus.fifo_level     = r_wrPtr - r_rdPtr;
    assign bus.overflow_count = r_overflow;
endmodule

// File: tb/tb_muon_coincidence_array.sv
// Bench for muon_coincidence_array: cycle-indexed window model feeds an expected-event queue,
// and a negedge monitor compares the DUT FIFO head and flags against it.
module tb_muon_coincidence_array;
    localparam int NUM_CH     = 4;
    localparam int MIN_HITS   = 2;
    localparam int WINDOW     = 8;
    localparam int TS_WIDTH   = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int DEADTIME   = 4;
`ifdef MUON_DEADTIME_EN
    localparam int DEAD_EFF = DEADTIME;
`else
    localparam int DEAD_EFF = 0;
`endif

    typedef struct {
        logic [63:0]       ts;
        logic [NUM_CH-1:0] mask;
    } entry_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    entry_t            expQ[$];
    int                modelOverflow = 0;
    logic [NUM_CH-1:0] prevHit = '0;
    logic [NUM_CH-1:0] edges;
    logic [NUM_CH-1:0] winMask = '0;
    logic              inWindow = 1'b0;
    logic [63:0]       cyc = '0;
    logic [63:0]       winStart = '0;
    logic [63:0]       reopenAt = '0;

    muon_coincidence_array_if #(
        .NUM_CH(NUM_CH), .TS_WIDTH(TS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    muon_coincidence_array #(
        .NUM_CH(NUM_CH), .MIN_HITS(MIN_HITS), .WINDOW(WINDOW),
        .TS_WIDTH(TS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] h, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            bus.hit   = h;
            bus.rd_en = r;
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: windows are tracked by absolute cycle index since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expQ.delete();
            modelOverflow = 0;
            prevHit       = '0;
            inWindow      = 1'b0;
            winMask       = '0;
            cyc           = '0;
            winStart      = '0;
            reopenAt      = '0;
        end else begin
            edges   = bus.hit & ~prevHit;
            prevHit = bus.hit;
            if (inWindow) begin
                winMask = winMask | edges;
                if (cyc - winStart == 64'(WINDOW - 1)) begin
                    inWindow = 1'b0;
                    reopenAt = cyc + 64'(1 + DEAD_EFF);
                    if ($countones(winMask) >= MIN_HITS) begin
                        if (expQ.size() < FIFO_DEPTH) expQ.push_back('{ts: winStart, mask: winMask});
                        else if (modelOverflow < 65535) modelOverflow++;
                    end
                end
            end else if (edges != '0 && cyc >= reopenAt) begin
                inWindow = 1'b1;
                winStart = cyc;
                winMask  = edges;
            end
            cyc = cyc + 64'd1;
        end
    end

    always @(negedge clk) begin
        checkOutput("buffer_empty", 64'(bus.buffer_empty), 64'(expQ.size() == 0));
        checkOutput("event_valid", 64'(bus.event_valid), 64'(expQ.size() != 0));
        checkOutput("buffer_full", 64'(bus.buffer_full), 64'(expQ.size() == FIFO_DEPTH));
        checkOutput("fifo_level", 64'(bus.fifo_level), 64'(expQ.size()));
        checkOutput("overflow_count", 64'(bus.overflow_count), 64'(modelOverflow));
        if (expQ.size() > 0) begin
            checkOutput("head_timestamp", bus.timestamp_out, expQ[0].ts);
            checkOutput("head_mask", 64'(bus.hit_mask_out), 64'(expQ[0].mask));
            if (bus.rd_en) void'(expQ.pop_front());
        end else begin
            checkOutput("empty_timestamp", bus.timestamp_out, 64'd0);
            checkOutput("empty_mask", 64'(bus.hit_mask_out), 64'd0);
        end
    end

    initial begin
        logic [NUM_CH-1:0] h;
        logic [NUM_CH-1:0] flips;
        logic              r;

        bus.hit   = '0;
        bus.rd_en = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_empty", 64'(bus.buffer_empty), 64'd1);
        checkOutput("reset_level", 64'(bus.fifo_level), 64'd0);
        reset_n = 1'b1;

        $display("[TB] coincidence within window");
        applyStimulus('0, 1'b0, 10);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus('0, 1'b0, 2);
        applyStimulus(4'b0010, 1'b0, 1);
        applyStimulus('0, 1'b0, 3);
        checkOutput("t1_valid_cycle17", 64'(bus.event_valid), 64'd0);
        applyStimulus('0, 1'b0, 1);
        checkOutput("t1_valid_cycle18", 64'(bus.event_valid), 64'd1);
        checkOutput("t1_timestamp", bus.timestamp_out, 64'd10);
        checkOutput("t1_mask", 64'(bus.hit_mask_out), 64'b0011);
        applyStimulus('0, 1'b1, 1);
        checkOutput("t1_empty_after_pop", 64'(bus.buffer_empty), 64'd1);
        applyStimulus('0, 1'b0, 4);

        $display("[TB] window miss then close pair");
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus('0, 1'b0, 9 + DEAD_EFF);
        checkOutput("t2_miss_empty", 64'(bus.buffer_empty), 64'd1);
        applyStimulus(4'b0010, 1'b0, 1);
        applyStimulus('0, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus('0, 1'b0, 12);
        checkOutput("t2_level", 64'(bus.fifo_level), 64'd1);
        checkOutput("t2_mask", 64'(bus.hit_mask_out), 64'b0110);
        applyStimulus('0, 1'b1, 1);
        applyStimulus('0, 1'b0, 13);

        $display("[TB] simultaneous held inputs");
        applyStimulus(4'b1001, 1'b0, 20);
        applyStimulus('0, 1'b0, 14);
        checkOutput("t3_level", 64'(bus.fifo_level), 64'd1);
        checkOutput("t3_mask", 64'(bus.hit_mask_out), 64'b1001);
        applyStimulus('0, 1'b1, 1);
        applyStimulus('0, 1'b0, 4);

        $display("[TB] fifo fill and overflow");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(4'b0011, 1'b0, 1);
            applyStimulus('0, 1'b0, 13);
            if (i == 15) begin
                checkOutput("t4_full_after16", 64'(bus.buffer_full), 64'd1);
                checkOutput("t4_level_after16", 64'(bus.fifo_level), 64'd16);
            end
        end
        checkOutput("t4_overflow", 64'(bus.overflow_count), 64'd2);
        applyStimulus(4'b0011, 1'b0, 1);
        applyStimulus('0, 1'b0, 6);
        applyStimulus('0, 1'b1, 1);
        applyStimulus('0, 1'b0, 6);
        checkOutput("t4_pushpop_level", 64'(bus.fifo_level), 64'd16);
        checkOutput("t4_pushpop_overflow", 64'(bus.overflow_count), 64'd2);
        applyStimulus('0, 1'b1, 16);
        checkOutput("t4_drained_empty", 64'(bus.buffer_empty), 64'd1);
        applyStimulus('0, 1'b0, 2);

        $display("[TB] post-window edges");
        applyStimulus(4'b0011, 1'b0, 1);
        applyStimulus('0, 1'b0, 8);
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1);
        applyStimulus('0, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus('0, 1'b0, 15);
        checkOutput("t6_level", 64'(bus.fifo_level), 64'd2);
        applyStimulus('0, 1'b1, 1);
`ifdef MUON_DEADTIME_EN
        checkOutput("t6_second_mask", 64'(bus.hit_mask_out), 64'b0101);
`else
        checkOutput("t6_second_mask", 64'(bus.hit_mask_out), 64'b1101);
`endif
        applyStimulus('0, 1'b1, 1);
        applyStimulus('0, 1'b0, 14);

        $display("[TB] reset mid-window");
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus('0, 1'b0, 1);
        reset_n = 1'b0;
        #2;
        checkOutput("t5_rst_empty", 64'(bus.buffer_empty), 64'd1);
        checkOutput("t5_rst_valid", 64'(bus.event_valid), 64'd0);
        checkOutput("t5_rst_full", 64'(bus.buffer_full), 64'd0);
        checkOutput("t5_rst_level", 64'(bus.fifo_level), 64'd0);
        checkOutput("t5_rst_overflow", 64'(bus.overflow_count), 64'd0);
        checkOutput("t5_rst_timestamp", bus.timestamp_out, 64'd0);
        checkOutput("t5_rst_mask", 64'(bus.hit_mask_out), 64'd0);
        applyStimulus('0, 1'b0, 3);
        reset_n = 1'b1;
        applyStimulus('0, 1'b0, 5);
        applyStimulus(4'b0010, 1'b0, 1);
        applyStimulus('0, 1'b0, 14);
        checkOutput("t5_no_entry", 64'(bus.buffer_empty), 64'd1);

        $display("[TB] randomized traffic");
        h = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NUM_CH; b++) flips[b] = ($urandom_range(0, 5) == 0);
            h = h ^ flips;
            if (c < 1500) r = ($urandom_range(0, 15) == 0);
            else          r = ($urandom_range(0, 1) == 0);
            applyStimulus(h, r, 1);
        end
        applyStimulus('0, 1'b1, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
